popcount_frame_accumulator: RTL and testbench
=============================================

# popcount_frame_accumulator

Consumes a stream of 3-bit words, computes the number of set bits in each word (the same 0..3 ones count produced by the `my_counter` stage), and accumulates two per-frame statistics over a fixed-length frame: the total ones count and the number of majority words (ones count >= 2). It sits directly downstream of the ones-count stage. The 3-bit words that feed `my_counter` arrive here over a valid/ready handshake, and one result per frame is presented to the consumer over a second valid/ready handshake.

## Interface

Parameters:
- `FRAME_LEN`, default 8: words per frame; legal values are 2..255.
- `SUM_W`, default 5: width of `out_sum`; must satisfy 2^SUM_W > 3*FRAME_LEN.
- `MAJ_W`, default 4: width of `out_maj`; must satisfy 2^MAJ_W > FRAME_LEN.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort; discards the partial frame or the pending result.
- `in_valid`, input, 1: `in_bits` is valid.
- `in_ready`, output, 1: the block accepts a word this cycle.
- `in_bits`, input, 3: input word.
- `out_valid`, output, 1: frame result is valid.
- `out_ready`, input, 1: the consumer takes the result.
- `out_sum`, output, SUM_W: total ones count of the frame.
- `out_maj`, output, MAJ_W: count of words in the frame with ones count >= 2.
- `frame_cnt`, output, 8: frames delivered since reset; wraps modulo 256.

## Operation

- There are two states, ACCUM and HOLD. Reset state is ACCUM.
- `in_ready` = 1 in ACCUM and 0 in HOLD. It is a registered-state decode only and does not depend on `in_valid`.
- A word is accepted when `in_valid` and `in_ready` are both 1 at a rising edge. On accept, in ACCUM:
  - sum += popcount(`in_bits`), a value in 0..3;
  - maj += 1 when popcount >= 2;
  - idx += 1.
- When an accept happens with idx == FRAME_LEN-1:
  - the final sum and maj, including that word, are loaded into `out_sum`/`out_maj`;
  - `out_valid` goes to 1;
  - the state moves to HOLD;
  - the internal sum, maj and idx are cleared.
- In HOLD:
  - `out_sum`, `out_maj` and `out_valid` are held stable until `out_valid` and `out_ready` are both 1 at a rising edge;
  - on that edge the state returns to ACCUM, `out_valid` drops to 0, and `frame_cnt` increments (255 -> 0).
- `out_sum` and `out_maj` keep the last delivered values while `out_valid` = 0.
- `clear` = 1 at a rising edge, in either state:
  - sum, maj and idx are cleared and the state goes to ACCUM;
  - `out_valid` drops to 0 and the pending result is discarded;
  - `frame_cnt` is not incremented.
- `clear` has priority over a simultaneous accept (the word is dropped) and over a simultaneous output handshake (no increment).
- Arithmetic: unsigned, no saturation. The parameter constraints guarantee no overflow.

## Timing

- Reset, asserted at any time and independent of `clk`, forces immediately:
  - state = ACCUM, `in_ready` = 1;
  - `out_valid` = 0, `out_sum` = 0, `out_maj` = 0, `frame_cnt` = 0;
  - internal sum, maj and idx = 0.
- Reset mid-frame or in HOLD loses all partial and pending data.
- Throughput: one word per cycle in ACCUM.
- Latency: if the last word of a frame is accepted at edge k, `out_valid` = 1 after edge k and `in_ready` = 0 after edge k.
- Output handshake at edge m: `in_ready` = 1 after edge m, so the first word of the next frame is accepted at edge m+1 at the earliest.
- Minimum frame period is FRAME_LEN+1 cycles, with one bubble per frame.
- `in_valid` deasserted mid-frame: the block waits indefinitely, and idx is retained.
- `in_valid` = 1 while in HOLD: the word is not accepted, and the upstream holds it.

## Test plan

- **Ramp frame.** After reset, drive 8 back-to-back words 000,001,...,111 with `out_ready` = 1.
  - After the 8th accept edge: `out_valid` = 1, `out_sum` = 12, `out_maj` = 4.
  - `frame_cnt` reads 1 after the handshake.
- **Saturated frame.** Drive 8 words of 111.
  - Result: `out_sum` = 24, `out_maj` = 8.
  - Then drive 8 words of 000: `out_sum` = 0, `out_maj` = 0.
- **Backpressure.** Complete a ramp frame with `out_ready` = 0 for 5 cycles.
  - `out_valid`, `out_sum` (12) and `out_maj` (4) stay stable, `in_ready` = 0, and words offered during this time are not consumed.
  - On the `out_ready` pulse: `in_ready` = 1 one cycle later and `frame_cnt` increments by exactly 1.
- **Clear mid-frame.** Accept 3 words of 111, pulse `clear` together with a valid 111 word, then send 8 words of 001.
  - Result: `out_sum` = 8, `out_maj` = 0.
  - `frame_cnt` is unchanged by the clear.
- **Async reset in HOLD.** Assert `rst_n` = 0 between clock edges while `out_valid` = 1.
  - `out_valid`, `out_sum`, `out_maj` and `frame_cnt` are 0 before the next edge, and `in_ready` = 1 after release.
- **Wrap and stall.** Run 256 frames with random `in_valid` gaps.
  - Each result matches the reference popcount model.
  - `frame_cnt` wraps 255 -> 0.

Source files
------------

// File: rtl/popcount_frame_accumulator.sv
// Per-frame ones-count and majority-word statistics over FRAME_LEN 3-bit words; result valid the cycle after the last accept.
// Backpressure: in_ready drops while a result waits in HOLD, so upstream stalls until the consumer takes it (one bubble per frame).
module popcount_frame_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 5,
  parameter int MAJ_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [MAJ_W-1:0] out_maj,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] IDX_LAST = 8'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_nxt;
  logic [MAJ_W-1:0] maj_q, maj_nxt;
  logic [7:0]       idx_q;
  logic [1:0]       pc;
  logic             accept, last_word, out_hs;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign pc        = {1'b0, in_bits[0]} + {1'b0, in_bits[1]} + {1'b0, in_bits[2]};
  assign accept    = in_valid && in_ready;
  assign last_word = (idx_q == IDX_LAST);
  assign out_hs    = out_valid && out_ready;

  // Running totals including the word currently on the bus
  assign sum_nxt = sum_q + SUM_W'(pc);
  assign maj_nxt = maj_q + MAJ_W'(pc[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_word) state_d = HOLD;
        HOLD:    if (out_hs) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // clear wins over both a simultaneous accept and a simultaneous output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      maj_q     <= '0;
      idx_q     <= '0;
      out_sum   <= '0;
      out_maj   <= '0;
      frame_cnt <= '0;
    end else if (clear) begin
      sum_q <= '0;
      maj_q <= '0;
      idx_q <= '0;
    end else begin
      if (accept) begin
        if (last_word) begin
          out_sum <= sum_nxt;
          out_maj <= maj_nxt;
          sum_q   <= '0;
          maj_q   <= '0;
          idx_q   <= '0;
        end else begin
          sum_q <= sum_nxt;
          maj_q <= maj_nxt;
          idx_q <= idx_q + 8'd1;
        end
      end
      if (out_hs) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Bench for popcount_frame_accumulator: directed frames feed a result queue, a monitor pops and compares on each output handshake.
module tb_popcount_frame_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int SUM_W     = 5;
  localparam int MAJ_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_bits = 3'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SUM_W-1:0] out_sum;
  logic [MAJ_W-1:0] out_maj;
  logic [7:0]       frame_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int sum;
    int maj;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] exp_fc = 8'd0;

  always #5 clk = ~clk;

  popcount_frame_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .SUM_W(SUM_W),
    .MAJ_W(MAJ_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_maj(out_maj),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: inputs change on the falling edge, so sample 1ns later
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", int'(out_sum), e.sum);
          chk("out_maj", int'(out_maj), e.maj);
        end
        chk("frame_cnt_at_hs", int'(frame_cnt), int'(exp_fc));
        exp_fc = exp_fc + 8'd1;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the word is accepted
  task automatic send(input logic [2:0] b);
    int n;
    n = 0;
    in_bits  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [2:0] w[FRAME_LEN]);
    res_t r;
    r.sum = 0;
    r.maj = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      r.sum += $countones(w[i]);
      if ($countones(w[i]) >= 2) r.maj++;
    end
    exp_q.push_back(r);
  endtask

  task automatic send_const(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  initial begin
    logic [2:0] w[FRAME_LEN];
    logic [7:0] fc_before;
    res_t       r;
    int         n;

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_maj", int'(out_maj), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp frame: 000..111 gives sum 12, maj 4
    r.sum = 12; r.maj = 4;
    exp_q.push_back(r);
    for (int i = 0; i < 8; i++) send(3'(i));
    in_valid = 1'b0;
    chk("ramp_out_valid", int'(out_valid), 1);
    chk("ramp_in_ready", int'(in_ready), 0);
    chk("ramp_sum_direct", int'(out_sum), 12);
    @(negedge clk);
    chk("ramp_frame_cnt", int'(frame_cnt), 1);
    chk("ramp_in_ready_after", int'(in_ready), 1);

    // Saturated then empty frames
    r.sum = 24; r.maj = 8;
    exp_q.push_back(r);
    send_const(3'b111, 8);
    r.sum = 0; r.maj = 0;
    exp_q.push_back(r);
    send_const(3'b000, 8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("zero_sum_held", int'(out_sum), 0);

    // Backpressure: result held for 5 cycles while a word is offered
    out_ready = 1'b0;
    r.sum = 12; r.maj = 4;
    exp_q.push_back(r);
    for (int i = 0; i < 8; i++) send(3'(i));
    in_bits  = 3'b111;
    in_valid = 1'b1;
    fc_before = frame_cnt;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_sum", int'(out_sum), 12);
      chk("bp_out_maj", int'(out_maj), 4);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_frame_cnt_inc", int'(frame_cnt), int'(fc_before + 8'd1));

    // Clear mid-frame, together with a valid word
    send_const(3'b111, 3);
    fc_before = frame_cnt;
    clear    = 1'b1;
    in_bits  = 3'b111;
    in_valid = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_frame_cnt", int'(frame_cnt), int'(fc_before));
    chk("clear_out_valid", int'(out_valid), 0);
    r.sum = 8; r.maj = 0;
    exp_q.push_back(r);
    send_const(3'b001, 8);
    in_valid = 1'b0;
    @(negedge clk);

    // Async reset while a result is pending
    out_ready = 1'b0;
    send_const(3'b111, 8);
    in_valid = 1'b0;
    chk("hold_out_valid", int'(out_valid), 1);
    chk("hold_out_sum", int'(out_sum), 24);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sum", int'(out_sum), 0);
    chk("arst_out_maj", int'(out_maj), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    exp_fc = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", int'(in_ready), 1);

    // 256 random frames with input gaps; frame_cnt wraps back to 0
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) w[i] = 3'($urandom_range(0, 7));
      push_frame(w);
      for (int i = 0; i < FRAME_LEN; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
        send(w[i]);
      end
      in_valid = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("wrap_frame_cnt", int'(frame_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
